dds_sweep_gen: RTL and testbench

- Next-generation quadrature DDS: parametrised phase accumulator, quarter-wave sine LUT, signed sin/cos outputs and amplitude scaling.
- Adds a programmable phase offset, accumulator clear, valid/ready configuration handshake, and a linear frequency-sweep FSM with one-shot and wrap modes.
- Sits between the control register block and the DAC interface; the sweep FSM drives the tuning word every cycle.

---
 rtl/dds_sweep_gen.sv | 265 ++++++++++++++++++++++++++
 tb/tb_dds_sweep_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_gen.sv
// dds_sweep_gen -- quadrature DDS with programmable linear frequency sweep.
//
// A phase accumulator advances by the active tuning word every cycle. A
// three-stage pipeline adds a phase offset, looks up a quarter-wave sine
// table, folds the quadrant into signed sine/cosine, and applies an
// amplitude gain. A small FSM (IDLE/RUN/DONE) steps the tuning word from
// f_start towards f_stop once per dwell period. It runs in either one-shot
// or wrap mode.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   cfg_valid/ready     configuration handshake (ready in IDLE and DONE)
//   cfg_f_start/stop    sweep start / stop tuning words
//   cfg_f_step          tuning-word increment per dwell period
//   cfg_dwell           cycles per step (0 behaves as 1)
//   cfg_wrap            1 = restart from f_start at the end, 0 = one-shot
//   cfg_phase_off       phase offset added after the accumulator
//   sweep_start/abort   sweep control pulses
//   phase_clr           synchronous accumulator clear
//   ampl                unsigned gain, unity = 2^AMP_WIDTH (larger values clamp)
//   sin_out, cos_out    signed quadrature outputs
//   out_valid           pipeline filled since reset
//   sweep_busy          FSM in RUN
//   sweep_done          one-cycle pulse at the end of each sweep pass
//   ftw_cur             active tuning word
module dds_sweep_gen #(
  parameter int PHASE_WIDTH = 28,
  parameter int ADDR_WIDTH  = 10,
  parameter int DAC_WIDTH   = 12,
  parameter int AMP_WIDTH   = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PHASE_WIDTH-1:0] cfg_f_start,
  input  logic [PHASE_WIDTH-1:0] cfg_f_stop,
  input  logic [PHASE_WIDTH-1:0] cfg_f_step,
  input  logic [15:0]            cfg_dwell,
  input  logic                   cfg_wrap,
  input  logic [PHASE_WIDTH-1:0] cfg_phase_off,
  input  logic                   sweep_start,
  input  logic                   sweep_abort,
  input  logic                   phase_clr,
  input  logic [AMP_WIDTH:0]     ampl,
  output logic [DAC_WIDTH-1:0]   sin_out,
  output logic [DAC_WIDTH-1:0]   cos_out,
  output logic                   out_valid,
  output logic                   sweep_busy,
  output logic                   sweep_done,
  output logic [PHASE_WIDTH-1:0] ftw_cur
);

  localparam int Q      = 2 ** (ADDR_WIDTH - 2);
  localparam int IW     = ADDR_WIDTH - 2;
  localparam int MW     = DAC_WIDTH - 1;
  localparam int PROD_W = DAC_WIDTH + AMP_WIDTH + 2;
  localparam logic [AMP_WIDTH:0] UNITY = {1'b1, {AMP_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  // Quarter-wave entry sampled at bin centres so that the fold stays symmetric.
  function automatic logic [MW-1:0] lut_entry(input int i);
    real m;
    real x;
    int  v;
    m = real'(2 ** (DAC_WIDTH - 1) - 1);
    x = m * $sin(3.14159265358979323846 / 2.0 * (real'(i) + 0.5) / real'(Q));
    v = $rtoi(x + 0.5);
    return v[MW-1:0];
  endfunction

  // Quadrant fold: odd quadrants read the table mirrored, upper half negates.
  function automatic logic signed [DAC_WIDTH-1:0] fold(input logic [1:0] q,
                                                        input logic [MW-1:0] dir,
                                                        input logic [MW-1:0] rev);
    logic [MW-1:0] mag;
    mag = q[0] ? rev : dir;
    if (q[1]) begin
      return -$signed({1'b0, mag});
    end else begin
      return $signed({1'b0, mag});
    end
  endfunction

  logic [MW-1:0] lut [Q];
  for (genvar g = 0; g < Q; g++) begin : g_lut
    assign lut[g] = lut_entry(g);
  end

  // Latched configuration
  logic [PHASE_WIDTH-1:0] f_start_r, f_stop_r, f_step_r, phase_off_r;
  logic [15:0]            dwell_r;
  logic                   wrap_r;

  // Sweep FSM
  state_t                 state_r, state_nxt;
  logic [15:0]            cnt_r, cnt_nxt, dwell_last;
  logic [PHASE_WIDTH-1:0] ftw_nxt;
  logic [PHASE_WIDTH:0]   step_sum;
  logic                   done_nxt;
  logic                   cfg_acc;

  // Datapath
  logic [PHASE_WIDTH-1:0]       acc_r, p_r;
  logic [ADDR_WIDTH-1:0]        addr;
  logic [1:0]                   quad, quad_cos;
  logic [IW-1:0]                idx;
  logic signed [DAC_WIDTH-1:0]  sin_s2_r, cos_s2_r;
  logic [AMP_WIDTH:0]           amp;
  logic signed [PROD_W-1:0]     sin_prod, cos_prod;
  logic [2:0]                   vld_sr_r;
  logic                         prod_unused;

  assign cfg_acc    = cfg_valid & cfg_ready;
  assign dwell_last = (dwell_r == 16'd0) ? 16'd0 : (dwell_r - 16'd1);
  assign step_sum   = {1'b0, ftw_cur} + {1'b0, f_step_r};

  assign addr     = p_r[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign quad     = addr[ADDR_WIDTH-1 -: 2];
  assign idx      = addr[IW-1:0];
  assign quad_cos = quad + 2'd1;

  // Configuration capture on an accepted handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_start_r   <= '0;
      f_stop_r    <= '0;
      f_step_r    <= '0;
      phase_off_r <= '0;
      dwell_r     <= 16'd0;
      wrap_r      <= 1'b0;
    end else if (cfg_acc) begin
      f_start_r   <= cfg_f_start;
      f_stop_r    <= cfg_f_stop;
      f_step_r    <= cfg_f_step;
      phase_off_r <= cfg_phase_off;
      dwell_r     <= cfg_dwell;
      wrap_r      <= cfg_wrap;
    end else begin
      f_start_r   <= f_start_r;
    end
  end

  // Sweep FSM next-state and tuning-word logic
  always_comb begin
    state_nxt = state_r;
    ftw_nxt   = ftw_cur;
    cnt_nxt   = cnt_r;
    done_nxt  = 1'b0;
    case (state_r)
      IDLE: begin
        // A config offered together with a start wins; the start is dropped.
        if (cfg_acc) begin
          ftw_nxt = cfg_f_start;
        end else if (sweep_start) begin
          state_nxt = RUN;
          ftw_nxt   = f_start_r;
          cnt_nxt   = 16'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        // Abort takes priority over a step that falls in the same cycle.
        if (sweep_abort) begin
          state_nxt = IDLE;
          ftw_nxt   = f_start_r;
        end else if (cnt_r == dwell_last) begin
          cnt_nxt = 16'd0;
          if (step_sum < {1'b0, f_stop_r}) begin
            ftw_nxt = step_sum[PHASE_WIDTH-1:0];
          end else if (wrap_r) begin
            ftw_nxt  = f_start_r;
            done_nxt = 1'b1;
          end else begin
            state_nxt = DONE;
            ftw_nxt   = f_stop_r;
            done_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_r + 16'd1;
        end
      end
      DONE: begin
        if (cfg_acc) begin
          state_nxt = IDLE;
          ftw_nxt   = cfg_f_start;
        end else if (sweep_abort) begin
          state_nxt = IDLE;
          ftw_nxt   = f_start_r;
        end else if (sweep_start) begin
          state_nxt = RUN;
          ftw_nxt   = f_start_r;
          cnt_nxt   = 16'd0;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        ftw_nxt   = f_start_r;
        cnt_nxt   = 16'd0;
      end
    endcase
  end

  // Sweep FSM state and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ftw_cur    <= '0;
      cnt_r      <= 16'd0;
      sweep_done <= 1'b0;
      sweep_busy <= 1'b0;
      cfg_ready  <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      ftw_cur    <= ftw_nxt;
      cnt_r      <= cnt_nxt;
      sweep_done <= done_nxt;
      sweep_busy <= (state_nxt == RUN);
      cfg_ready  <= (state_nxt != RUN);
    end
  end

  // Gain clamp and full-width products; floor comes from the arithmetic shift.
  always_comb begin
    amp      = (ampl > UNITY) ? UNITY : ampl;
    sin_prod = PROD_W'(sin_s2_r) * PROD_W'($signed({1'b0, amp}));
    cos_prod = PROD_W'(cos_s2_r) * PROD_W'($signed({1'b0, amp}));
  end

  // Low fraction bits and the guard bits of the products are never needed.
  assign prod_unused = ^{sin_prod[AMP_WIDTH-1:0], sin_prod[PROD_W-1 -: 2],
                         cos_prod[AMP_WIDTH-1:0], cos_prod[PROD_W-1 -: 2]};

  // Phase accumulator, offset add, table fold and output scale pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r     <= '0;
      p_r       <= '0;
      sin_s2_r  <= '0;
      cos_s2_r  <= '0;
      sin_out   <= '0;
      cos_out   <= '0;
      vld_sr_r  <= 3'd0;
      out_valid <= 1'b0;
    end else begin
      if (phase_clr) begin
        acc_r <= '0;
      end else begin
        acc_r <= acc_r + ftw_cur;
      end
      p_r       <= acc_r + phase_off_r;
      sin_s2_r  <= fold(quad, lut[idx], lut[~idx]);
      cos_s2_r  <= fold(quad_cos, lut[idx], lut[~idx]);
      sin_out   <= sin_prod[AMP_WIDTH +: DAC_WIDTH];
      cos_out   <= cos_prod[AMP_WIDTH +: DAC_WIDTH];
      vld_sr_r  <= {vld_sr_r[1:0], 1'b1};
      out_valid <= vld_sr_r[2];
    end
  end

endmodule

// File: tb/tb_dds_sweep_gen.sv
module tb_dds_sweep_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [27:0] cfg_f_start, cfg_f_stop, cfg_f_step, cfg_phase_off;
  logic [15:0] cfg_dwell;
  logic        cfg_wrap;
  logic        sweep_start, sweep_abort, phase_clr;
  logic [12:0] ampl;
  logic [11:0] sin_out, cos_out;
  logic        out_valid, sweep_busy, sweep_done;
  logic [27:0] ftw_cur;

  int vectors = 0;
  int miscompares = 0;

  dds_sweep_gen dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
    .cfg_dwell(cfg_dwell), .cfg_wrap(cfg_wrap), .cfg_phase_off(cfg_phase_off),
    .sweep_start(sweep_start), .sweep_abort(sweep_abort), .phase_clr(phase_clr),
    .ampl(ampl), .sin_out(sin_out), .cos_out(cos_out), .out_valid(out_valid),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done), .ftw_cur(ftw_cur)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [27:0] fs, input logic [27:0] fe, input logic [27:0] st,
                        input logic [15:0] dw, input logic wr, input logic [27:0] off);
    cfg_f_start = fs; cfg_f_stop = fe; cfg_f_step = st;
    cfg_dwell = dw; cfg_wrap = wr; cfg_phase_off = off;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if ({sin_out, cos_out, out_valid, sweep_busy, sweep_done, cfg_ready, ftw_cur} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs sin=%0d cos=%0d valid=%b busy=%b done=%b ready=%b ftw=%0d, all should be 0",
               sin_out, cos_out, out_valid, sweep_busy, sweep_done, cfg_ready, ftw_cur);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      vectors++;
      if (out_valid !== (k >= 3)) begin
        miscompares++;
        $display("FAIL reset_out_valid cycle %0d got %b exp %b", k, out_valid, (k >= 3));
      end
      if (k == 0) begin
        vectors++;
        if (cfg_ready !== 1'b1 || ftw_cur !== 28'd0) begin
          miscompares++;
          $display("FAIL reset_idle ready=%b ftw=%0d exp ready=1 ftw=0", cfg_ready, ftw_cur);
        end
      end
      if (k >= 3) begin
        vectors++;
        if ($signed(sin_out) !== 6 || $signed(cos_out) !== 2047) begin
          miscompares++;
          $display("FAIL reset_dc cycle %0d sin=%0d cos=%0d exp 6/2047", k, $signed(sin_out), $signed(cos_out));
        end
      end
    end
  endtask

  // Clears the accumulator and checks eight outputs from three cycles later.
  task automatic test_tone(input string name, input logic [12:0] a,
                           input int e0, input int e1, input int e2, input int e3);
    int exp_v [4];
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
    ampl = a;
    phase_clr = 1'b1;
    tick();
    phase_clr = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      vectors++;
      if ($signed(sin_out) !== exp_v[k % 4] || $signed(cos_out) !== exp_v[(k + 1) % 4]) begin
        miscompares++;
        $display("FAIL %s k=%0d sin=%0d cos=%0d exp %0d/%0d", name, k,
                 $signed(sin_out), $signed(cos_out), exp_v[k % 4], exp_v[(k + 1) % 4]);
      end
    end
  endtask

  task automatic test_oneshot();
    // Config and start together: config wins, start ignored.
    cfg_f_start = 28'd100; cfg_f_stop = 28'd300; cfg_f_step = 28'd50;
    cfg_dwell = 16'd2; cfg_wrap = 1'b0; cfg_phase_off = 28'd0;
    cfg_valid = 1'b1; sweep_start = 1'b1;
    tick();
    cfg_valid = 1'b0; sweep_start = 1'b0;
    vectors++;
    if (sweep_busy !== 1'b0 || ftw_cur !== 28'd100 || cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_beats_start busy=%b ftw=%0d ready=%b exp 0/100/1", sweep_busy, ftw_cur, cfg_ready);
    end
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    vectors++;
    if (sweep_busy !== 1'b1 || ftw_cur !== 28'd100 || cfg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL oneshot_enter busy=%b ftw=%0d ready=%b exp 1/100/0", sweep_busy, ftw_cur, cfg_ready);
    end
    for (int k = 1; k <= 9; k++) begin
      int ef;
      ef = (k >= 8) ? 300 : 100 + 50 * (k / 2);
      tick();
      vectors++;
      if (ftw_cur !== 28'(ef) || sweep_done !== (k == 8) || sweep_busy !== (k < 8) || cfg_ready !== (k >= 8)) begin
        miscompares++;
        $display("FAIL oneshot t+%0d ftw=%0d done=%b busy=%b ready=%b exp %0d/%b/%b/%b", k, ftw_cur,
                 sweep_done, sweep_busy, cfg_ready, ef, (k == 8), (k < 8), (k >= 8));
      end
    end
  endtask

  task automatic test_wrap();
    do_cfg(28'd100, 28'd300, 28'd50, 16'd2, 1'b1, 28'd0);
    vectors++;
    if (sweep_busy !== 1'b0 || ftw_cur !== 28'd100 || cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_in_done busy=%b ftw=%0d ready=%b exp 0/100/1", sweep_busy, ftw_cur, cfg_ready);
    end
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    // A config offered during RUN must not be taken.
    cfg_f_start = 28'd5000; cfg_f_stop = 28'd9000; cfg_f_step = 28'd7;
    cfg_dwell = 16'd1; cfg_wrap = 1'b0;
    cfg_valid = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      int ef;
      if (k == 18) cfg_valid = 1'b0;
      ef = 100 + 50 * ((k % 8) / 2);
      tick();
      vectors++;
      if (ftw_cur !== 28'(ef) || sweep_done !== (k == 8 || k == 16) || sweep_busy !== 1'b1 || cfg_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL wrap t+%0d ftw=%0d done=%b busy=%b ready=%b exp %0d/%b/1/0", k, ftw_cur,
                 sweep_done, sweep_busy, cfg_ready, ef, (k == 8 || k == 16));
      end
    end
    // Abort lands on a step edge (t+22 would step to 250).
    sweep_abort = 1'b1;
    tick();
    sweep_abort = 1'b0;
    vectors++;
    if (ftw_cur !== 28'd100 || sweep_busy !== 1'b0 || sweep_done !== 1'b0 || cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_on_step ftw=%0d busy=%b done=%b ready=%b exp 100/0/0/1", ftw_cur, sweep_busy, sweep_done, cfg_ready);
    end
    tick();
    vectors++;
    if (ftw_cur !== 28'd100 || sweep_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_hold ftw=%0d done=%b exp 100/0", ftw_cur, sweep_done);
    end
  endtask

  task automatic test_abort();
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    tick(); tick(); tick(); tick();
    vectors++;
    if (ftw_cur !== 28'd200 || sweep_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre ftw=%0d busy=%b exp 200/1", ftw_cur, sweep_busy);
    end
    sweep_abort = 1'b1;
    tick();
    sweep_abort = 1'b0;
    vectors++;
    if (ftw_cur !== 28'd100 || sweep_busy !== 1'b0 || sweep_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_t5 ftw=%0d busy=%b done=%b exp 100/0/0", ftw_cur, sweep_busy, sweep_done);
    end
  endtask

  task automatic test_reset_mid_sweep();
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({sin_out, cos_out, out_valid, sweep_busy, sweep_done, cfg_ready, ftw_cur} !== '0) begin
      miscompares++;
      $display("FAIL async_reset sin=%0d cos=%0d valid=%b busy=%b done=%b ready=%b ftw=%0d, all should be 0",
               sin_out, cos_out, out_valid, sweep_busy, sweep_done, cfg_ready, ftw_cur);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (ftw_cur !== 28'd0 || sweep_busy !== 1'b0 || cfg_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset ftw=%0d busy=%b ready=%b valid=%b exp 0/0/1/0", ftw_cur, sweep_busy, cfg_ready, out_valid);
    end
    // Config is now all zero: dwell 0 acts as 1, and f_start >= f_stop ends at once, one-shot.
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    vectors++;
    if (sweep_busy !== 1'b1 || ftw_cur !== 28'd0) begin
      miscompares++;
      $display("FAIL zero_cfg_run busy=%b ftw=%0d exp 1/0", sweep_busy, ftw_cur);
    end
    tick();
    vectors++;
    if (sweep_busy !== 1'b0 || sweep_done !== 1'b1 || ftw_cur !== 28'd0 || cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_cfg_done busy=%b done=%b ftw=%0d ready=%b exp 0/1/0/1", sweep_busy, sweep_done, ftw_cur, cfg_ready);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_f_start = 28'd0; cfg_f_stop = 28'd0; cfg_f_step = 28'd0;
    cfg_dwell = 16'd0; cfg_wrap = 1'b0; cfg_phase_off = 28'd0;
    sweep_start = 1'b0; sweep_abort = 1'b0; phase_clr = 1'b0;
    ampl = 13'd4096;
    test_reset();
    do_cfg(28'h400_0000, 28'd0, 28'd0, 16'd0, 1'b0, 28'd0);
    test_tone("tone_unity", 13'd4096, 6, 2047, -6, -2047);
    test_tone("tone_half", 13'd2048, 3, 1023, -3, -1024);
    test_tone("tone_clamp", 13'd8191, 6, 2047, -6, -2047);
    test_tone("tone_zero", 13'd0, 0, 0, 0, 0);
    do_cfg(28'h400_0000, 28'd0, 28'd0, 16'd0, 1'b0, 28'h400_0000);
    test_tone("tone_phase_off", 13'd4096, 2047, -6, -2047, 6);
    test_oneshot();
    test_wrap();
    test_abort();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
